// File: rtl/imem_loader_ram_pkg.sv
// Shared definitions for the instruction-memory loader.
// Holds the FSM state encoding and a small helper for validating load lengths.
package imem_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_READY = 2'd2
    } state_t;

    // A load length is usable when it is non-zero and fits in the array.
    function automatic logic len_legal(input logic [31:0] len, input logic [31:0] depth);
        return (len != 32'd0) && (len <= depth);
    endfunction

endpackage

// File: rtl/imem_sp_array.sv
// Single-port storage array.
// One shared address, synchronous write, and a registered read.
// Writes take priority over reads. Only the read register is reset; the
// storage keeps its contents through reset.
module imem_sp_array #(
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [WIDTH-1:0]      wdata,
    output logic [WIDTH-1:0]      rdata
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage write; no reset so program contents survive a reset.
    always_ff @(posedge clk) begin
        if (we)
            mem[addr] <= wdata;
    end

    // Registered read port; it holds its last value when no read is issued.
    always_ff @(posedge clk) begin
        if (rst)
            rdata <= '0;
        else if (re && !we)
            rdata <= mem[addr];
    end

endmodule

// File: rtl/imem_loader_ram.sv
// Instruction memory with a streaming program loader.
// A load is started with load_start/load_len, then words are streamed in on a
// valid/ready handshake. Once the load completes, the memory serves fetches
// with one cycle of latency.
// Optional feature: define IMEM_PARITY_EN to store an even-parity bit per word
// and add the parity_err output.
module imem_loader_ram
    import imem_pkg::*;
#(
    parameter int DWIDTH     = 16,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_start,
    input  logic [ADDR_WIDTH:0]   load_len,
    input  logic                  load_valid,
    input  logic [DWIDTH-1:0]     load_data,
    output logic                  load_ready,
    input  logic                  fetch_en,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    output logic [DWIDTH-1:0]     fetch_data,
    output logic                  fetch_valid,
    output logic                  busy,
    output logic                  done
`ifdef IMEM_PARITY_EN
    ,
    output logic                  parity_err
`endif
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
`ifdef IMEM_PARITY_EN
    localparam int MW = DWIDTH + 1;
`else
    localparam int MW = DWIDTH;
`endif

    state_t                state;
    logic [ADDR_WIDTH:0]   len_q;
    logic [ADDR_WIDTH:0]   cnt;
    logic [ADDR_WIDTH:0]   cnt_nxt;
    logic                  start_ok;
    logic                  wr_acc;
    logic                  fetch_go;
    logic [ADDR_WIDTH-1:0] arr_addr;
    logic [MW-1:0]         arr_wdata;
    logic [MW-1:0]         arr_rdata;

    // Handshake decode: accepted starts, accepted words, and legal fetches.
    // A fetch that coincides with an accepted restart is dropped because the
    // array port is handed to the loader on the next cycle.
    always_comb begin
        start_ok = load_start && (state != ST_LOAD)
                   && len_legal(32'(load_len), 32'(DEPTH));
        wr_acc   = load_valid && (state == ST_LOAD);
        fetch_go = fetch_en && (state == ST_READY) && !start_ok;
        cnt_nxt  = cnt + 1'b1;
        arr_addr = (state == ST_LOAD) ? cnt[ADDR_WIDTH-1:0] : fetch_addr;
    end

`ifdef IMEM_PARITY_EN
    // Even parity: the stored word plus its parity bit XOR to zero.
    assign arr_wdata  = {^load_data, load_data};
    assign parity_err = fetch_valid && (^arr_rdata);
`else
    assign arr_wdata = load_data;
`endif

    assign fetch_data = arr_rdata[DWIDTH-1:0];

    // Loader FSM with registered busy/load_ready/done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            len_q      <= '0;
            cnt        <= '0;
            busy       <= 1'b0;
            load_ready <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE, ST_READY: begin
                    if (start_ok) begin
                        state      <= ST_LOAD;
                        len_q      <= load_len;
                        cnt        <= '0;
                        busy       <= 1'b1;
                        load_ready <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (wr_acc) begin
                        cnt <= cnt_nxt;
                        if (cnt_nxt == len_q) begin
                            state      <= ST_READY;
                            busy       <= 1'b0;
                            load_ready <= 1'b0;
                            done       <= 1'b1;
                        end
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    busy       <= 1'b0;
                    load_ready <= 1'b0;
                end
            endcase
        end
    end

    // fetch_valid marks the cycle the array read register holds a new word.
    always_ff @(posedge clk) begin
        if (rst)
            fetch_valid <= 1'b0;
        else
            fetch_valid <= fetch_go;
    end

    imem_sp_array #(
        .WIDTH      (MW),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_acc),
        .re    (fetch_go),
        .addr  (arr_addr),
        .wdata (arr_wdata),
        .rdata (arr_rdata)
    );

endmodule

// File: tb/tb_imem_loader_ram.sv
// Directed bench for imem_loader_ram: loads, back-pressure, illegal starts,
// reset mid-load, full-depth load/reload and, with IMEM_PARITY_EN, parity.
module tb_imem_loader_ram;

    localparam int DW    = 16;
    localparam int AW    = 8;
    localparam int DEPTH = 2 ** AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_start;
    logic [AW:0]   load_len;
    logic          load_valid;
    logic [DW-1:0] load_data;
    logic          load_ready;
    logic          fetch_en;
    logic [AW-1:0] fetch_addr;
    logic [DW-1:0] fetch_data;
    logic          fetch_valid;
    logic          busy;
    logic          done;
`ifdef IMEM_PARITY_EN
    logic          parity_err;
`endif

    int n_cmp = 0;
    int n_err = 0;

    imem_loader_ram #(.DWIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .load_start  (load_start),
        .load_len    (load_len),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_ready  (load_ready),
        .fetch_en    (fetch_en),
        .fetch_addr  (fetch_addr),
        .fetch_data  (fetch_data),
        .fetch_valid (fetch_valid),
        .busy        (busy),
        .done        (done)
`ifdef IMEM_PARITY_EN
        ,
        .parity_err  (parity_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] exp;
    } fvec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_start(input int len);
        load_start = 1'b1;
        load_len   = (AW+1)'(len);
        tick();
        load_start = 1'b0;
    endtask

    task automatic push(input logic [DW-1:0] w);
        load_valid = 1'b1;
        load_data  = w;
        tick();
        load_valid = 1'b0;
    endtask

    task automatic fetch(input string nm, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        fetch_en   = 1'b1;
        fetch_addr = a;
        tick();
        fetch_en   = 1'b0;
        chk({nm, "_valid"}, 32'(fetch_valid), 32'd1);
        chk({nm, "_data"}, 32'(fetch_data), 32'(exp));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        fvec_t vec [6];
        logic [DW-1:0] held;
        int done_cnt;

        rst = 1'b1; load_start = 1'b0; load_len = '0; load_valid = 1'b0;
        load_data = '0; fetch_en = 1'b0; fetch_addr = '0;
        do_reset();

        // Reset state
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(load_ready), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_fvalid", 32'(fetch_valid), 32'd0);
        chk("rst_fdata", 32'(fetch_data), 32'd0);

        // Fetch in IDLE is rejected
        fetch_en = 1'b1; fetch_addr = '0; tick(); fetch_en = 1'b0;
        chk("idle_fetch", 32'(fetch_valid), 32'd0);

        // Basic load of four words
        do_start(4);
        chk("basic_busy", 32'(busy), 32'd1);
        chk("basic_ready", 32'(load_ready), 32'd1);
        push(16'h1111); push(16'h2222); push(16'h3333);
        chk("basic_nodone", 32'(done), 32'd0);
        push(16'h4444);
        chk("basic_done", 32'(done), 32'd1);
        chk("basic_busy_off", 32'(busy), 32'd0);
        tick();
        chk("basic_done_pulse", 32'(done), 32'd0);

        // Table-driven fetches
        vec[0] = '{addr: 8'd2, exp: 16'h3333};
        vec[1] = '{addr: 8'd0, exp: 16'h1111};
        vec[2] = '{addr: 8'd3, exp: 16'h4444};
        vec[3] = '{addr: 8'd1, exp: 16'h2222};
        vec[4] = '{addr: 8'd2, exp: 16'h3333};
        vec[5] = '{addr: 8'd0, exp: 16'h1111};
        for (int i = 0; i < 6; i++)
            fetch($sformatf("tbl%0d", i), vec[i].addr, vec[i].exp);

        // fetch_data holds when fetch_en is low
        held = fetch_data;
        fetch_addr = 8'd3;
        tick();
        chk("hold_valid", 32'(fetch_valid), 32'd0);
        chk("hold_data", 32'(fetch_data), 32'(held));

        // Restart from READY with a simultaneous fetch: fetch dropped
        fetch_en = 1'b1; fetch_addr = 8'd1;
        do_start(3);
        fetch_en = 1'b0;
        chk("restart_fvalid", 32'(fetch_valid), 32'd0);
        chk("restart_busy", 32'(busy), 32'd1);

        // Back-pressure: valid on alternate cycles, plus a start during LOAD
        done_cnt = 0;
        for (int k = 0; k < 5; k++) begin
            load_valid = (k % 2 == 0);
            load_data  = 16'hB000 + 16'(k / 2);
            load_start = (k == 1);
            load_len   = 9'd1;
            tick();
            if (done) done_cnt++;
            if (k < 4) chk($sformatf("bp_busy%0d", k), 32'(busy), 32'd1);
        end
        load_valid = 1'b0; load_start = 1'b0;
        chk("bp_done", 32'(done), 32'd1);
        tick();
        if (done) done_cnt++;
        chk("bp_done_once", 32'(done_cnt), 32'd1);
        fetch("bp0", 8'd0, 16'hB000);
        fetch("bp1", 8'd1, 16'hB001);
        fetch("bp2", 8'd2, 16'hB002);
        fetch("bp_keep3", 8'd3, 16'h4444);

        // Illegal starts from IDLE
        do_reset();
        do_start(0);
        chk("ill0_busy", 32'(busy), 32'd0);
        do_start(DEPTH + 1);
        chk("ill1_busy", 32'(busy), 32'd0);
        chk("ill1_ready", 32'(load_ready), 32'd0);
        fetch_en = 1'b1; fetch_addr = 8'd0; tick(); fetch_en = 1'b0;
        chk("ill_fetch", 32'(fetch_valid), 32'd0);

        // Reset mid-load keeps partial words
        do_start(5);
        push(16'h5550); push(16'h5551);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_ready", 32'(load_ready), 32'd0);
        chk("mid_fdata", 32'(fetch_data), 32'd0);
        do_start(1);
        push(16'hABCD);
        chk("mid_done", 32'(done), 32'd1);
        fetch("mid_a1", 8'd1, 16'h5551);
        fetch("mid_a0", 8'd0, 16'hABCD);

        // Full depth load then partial reload
        do_start(DEPTH);
        for (int i = 0; i < DEPTH; i++) push(DW'(i));
        chk("full_done", 32'(done), 32'd1);
        fetch("full_last", 8'(DEPTH - 1), 16'(DEPTH - 1));
        fetch("full_first", 8'd0, 16'd0);
        do_start(1);
        push(16'hFFFF);
        fetch("reload_a0", 8'd0, 16'hFFFF);
        fetch("reload_a1", 8'd1, 16'd1);
        fetch("reload_last", 8'(DEPTH - 1), 16'(DEPTH - 1));

`ifdef IMEM_PARITY_EN
        fetch("par_clean", 8'd5, 16'd5);
        chk("par_clean_err", 32'(parity_err), 32'd0);
        dut.u_array.mem[0][0] = ~dut.u_array.mem[0][0];
        fetch_en = 1'b1; fetch_addr = 8'd0; tick(); fetch_en = 1'b0;
        chk("par_valid", 32'(fetch_valid), 32'd1);
        chk("par_err", 32'(parity_err), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
